// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift/rotate unit: mode codes and FSM state encoding.
package shift_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/shift1_step.sv
// Combinational single-bit shift/rotate step; returns the next word and the bit moved out.
module shift1_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  always_comb begin
    data_o  = data_i;
    carry_o = 1'b0;
    case (mode_i)
      MODE_SLL: begin
        data_o  = {data_i[WIDTH-2:0], 1'b0};
        carry_o = data_i[WIDTH-1];
      end
      MODE_SRL: begin
        data_o  = {1'b0, data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      MODE_SRA: begin
        data_o  = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      MODE_ROL: begin
        data_o  = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        carry_o = data_i[WIDTH-1];
      end
      MODE_ROR: begin
        data_o  = {data_i[0], data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      // Reserved codes pass data through with carry cleared, keeping normal timing.
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequential shift/rotate unit: one bit per clock, valid/ready on both sides, carry and zero flags.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SH_W  = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [SH_W-1:0]  in_amt_i,
  input  logic [2:0]       in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_carry_o,
  output logic             out_zero_o
);

  localparam logic [SH_W-1:0] CntOne = SH_W'(1);

  state_e           state_q, state_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [2:0]       mode_q, mode_d;

  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  shift1_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i  (data_q),
    .mode_i  (mode_q),
    .data_o  (step_data),
    .carry_o (step_carry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i && !flush_i) begin
          data_d  = in_data_i;
          mode_d  = in_mode_i;
          cnt_d   = in_amt_i;
          carry_d = 1'b0;
          state_d = (in_amt_i == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d  = step_data;
        carry_d = step_carry;
        cnt_d   = cnt_q - CntOne;
        if (cnt_q == CntOne) state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over every transition, including acceptance in idle.
    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_SLL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign out_data_o  = data_q;
  assign out_carry_o = carry_q;
  assign out_zero_o  = (data_q == '0);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit with an expected-result queue and immediate assertions.
module tb_shift_seq_unit;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [2:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_zero;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       zero;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_seq_unit #(
    .WIDTH (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_amt_i    (in_amt),
    .in_mode_i   (in_mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_carry_o (out_carry),
    .out_zero_o  (out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand, record the expected result, then scramble amt/mode to prove they are ignored.
  task automatic issue(input logic [7:0] d, input logic [2:0] amt, input logic [2:0] mode,
                       input logic [7:0] ed, input logic ec);
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt;
    in_mode  = mode;
    e.data   = ed;
    e.carry  = ec;
    e.zero   = (ed == 8'h00);
    e.lat    = int'(amt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_amt   = ~amt;
    in_mode  = ~mode;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   cyc;
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_data", {24'd0, out_data}, {24'd0, e.data});
    chk("out_carry", {31'd0, out_carry}, {31'd0, e.carry});
    chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {24'd0, out_data}, {24'd0, e.data});
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_ni    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    in_mode   = MODE_SLL;
    out_ready = 1'b0;
    #1 rst_ni = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_carry", {31'd0, out_carry}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;

    issue(8'h96, 3'd3, MODE_SLL, 8'hB0, 1'b0); collect(0);
    issue(8'h96, 3'd2, MODE_SRA, 8'hE5, 1'b1); collect(0);
    issue(8'h81, 3'd1, MODE_ROR, 8'hC0, 1'b1); collect(0);
    issue(8'h81, 3'd7, MODE_ROL, 8'hC0, 1'b0); collect(0);
    issue(8'h5A, 3'd0, MODE_SRL, 8'h5A, 1'b0); collect(4);
    issue(8'h80, 3'd1, MODE_SLL, 8'h00, 1'b1); collect(0);
    issue(8'h3C, 3'd5, 3'b111,   8'h3C, 1'b0); collect(0);
    issue(8'h5A, 3'd7, MODE_SRL, 8'h00, 1'b1); collect(0);

    // Flush arriving in the cycle of the third shift step.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_amt   = 3'd7;
    in_mode  = MODE_SLL;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("flush_busy", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end

    // Flush together with a request in idle: nothing may be accepted.
    in_valid = 1'b1;
    flush    = 1'b1;
    in_data  = 8'h33;
    in_amt   = 3'd0;
    in_mode  = MODE_SRL;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a shift.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_amt   = 3'd6;
    in_mode  = MODE_SLL;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_out_carry", {31'd0, out_carry}, 32'd0);
    chk("arst_out_zero", {31'd0, out_zero}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    issue(8'h01, 3'd4, MODE_SLL, 8'h10, 1'b0); collect(0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
